multicycle_control: RTL



---
 rtl/multicycle_control.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/multicycle_control.sv
// multicycle_control: sequences each MIPS instruction through fetch/decode/execute/memory/write-back and drives the datapath controls.
// Latency: one state per clock; lw 5, sw/R-type/addi 4, beq/j/jal/jr 3 cycles, plus one per memory wait cycle.
// Backpressure: memReady low holds FETCH/MEMRD/MEMWR; a watchdog traps a stalled access into a sticky ERROR state.
module multicycle_control #(
   parameter int OPCODE_W    = 6,
   parameter int MEM_TIMEOUT = 16
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [OPCODE_W-1:0] opCode,
   input  logic                memReady,
   output logic                PCWrite,
   output logic                PCWriteCond,
   output logic                IorD,
   output logic                MemRead,
   output logic                MemWrite,
   output logic                IRWrite,
   output logic                MemtoReg,
   output logic                RegWrite,
   output logic                RegDst,
   output logic                ALUSrcA,
   output logic [1:0]          ALUSrcB,
   output logic [1:0]          ALUOp,
   output logic [1:0]          PCSource,
   output logic                RegDstJAL,
   output logic                MemtoRegJAL,
   output logic                memError,
   output logic [3:0]          state
);

   // A zero timeout disables the watchdog; keep the counter at least one bit wide.
   localparam int CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

   localparam logic [OPCODE_W-1:0] OP_LW   = OPCODE_W'(6'b100011);
   localparam logic [OPCODE_W-1:0] OP_SW   = OPCODE_W'(6'b101011);
   localparam logic [OPCODE_W-1:0] OP_BEQ  = OPCODE_W'(6'b000100);
   localparam logic [OPCODE_W-1:0] OP_J    = OPCODE_W'(6'b000010);
   localparam logic [OPCODE_W-1:0] OP_JAL  = OPCODE_W'(6'b000011);
   localparam logic [OPCODE_W-1:0] OP_JR   = OPCODE_W'(6'b010000);
   localparam logic [OPCODE_W-1:0] OP_ADDI = OPCODE_W'(6'b001000);

   typedef enum logic [3:0] {
      FETCH  = 4'd0,
      DECODE = 4'd1,
      MEMADR = 4'd2,
      MEMRD  = 4'd3,
      MEMWB  = 4'd4,
      MEMWR  = 4'd5,
      EXEC   = 4'd6,
      ALUWB  = 4'd7,
      BRANCH = 4'd8,
      JUMP   = 4'd9,
      ADDIEX = 4'd10,
      ADDIWB = 4'd11,
      JAL    = 4'd12,
      JR     = 4'd13,
      ERROR  = 4'd15
   } state_t;

   // Moore part of the control word; the FETCH IRWrite/PCWrite term is added combinationally.
   typedef struct packed {
      logic       pcWrite;
      logic       pcWriteCond;
      logic       iorD;
      logic       memRead;
      logic       memWrite;
      logic       memtoReg;
      logic       regWrite;
      logic       regDst;
      logic       aluSrcA;
      logic [1:0] aluSrcB;
      logic [1:0] aluOp;
      logic [1:0] pcSource;
      logic       regDstJal;
      logic       memtoRegJal;
      logic       memError;
   } ctrl_t;

   state_t           stateQ;
   state_t           nextState;
   ctrl_t            ctrlQ;
   logic [CNT_W-1:0] waitCnt;
   logic             waiting;
   logic             timeout;

   function automatic ctrl_t decodeCtrl(input state_t s);
      ctrl_t c;
      c = '0;
      case (s)
         FETCH:  begin c.memRead = 1'b1; c.aluSrcB = 2'b01; end
         DECODE: begin c.aluSrcB = 2'b11; end
         MEMADR: begin c.aluSrcA = 1'b1; c.aluSrcB = 2'b10; end
         MEMRD:  begin c.memRead = 1'b1; c.iorD = 1'b1; end
         MEMWB:  begin c.memtoReg = 1'b1; c.regWrite = 1'b1; end
         MEMWR:  begin c.memWrite = 1'b1; c.iorD = 1'b1; end
         EXEC:   begin c.aluSrcA = 1'b1; c.aluOp = 2'b10; end
         ALUWB:  begin c.regDst = 1'b1; c.regWrite = 1'b1; end
         BRANCH: begin
            c.aluSrcA = 1'b1; c.aluOp = 2'b01; c.pcWriteCond = 1'b1; c.pcSource = 2'b01;
         end
         JUMP:   begin c.pcWrite = 1'b1; c.pcSource = 2'b10; end
         JAL:    begin
            c.pcWrite = 1'b1; c.pcSource = 2'b10; c.regWrite = 1'b1;
            c.regDstJal = 1'b1; c.memtoRegJal = 1'b1;
         end
         JR:     begin c.pcWrite = 1'b1; c.pcSource = 2'b11; end
         ADDIEX: begin c.aluSrcA = 1'b1; c.aluSrcB = 2'b10; end
         ADDIWB: begin c.regWrite = 1'b1; end
         default: c.memError = 1'b1;
      endcase
      return c;
   endfunction

   // Next-state selection, including the watchdog trap on a stalled memory access.
   always_comb begin
      waiting   = (stateQ == FETCH) || (stateQ == MEMRD) || (stateQ == MEMWR);
      timeout   = (MEM_TIMEOUT != 0) && waiting && !memReady &&
                  (waitCnt == CNT_W'(MEM_TIMEOUT - 1));
      nextState = stateQ;
      case (stateQ)
         FETCH:  if (memReady) nextState = DECODE; else if (timeout) nextState = ERROR;
         DECODE: begin
            if (opCode == OP_LW || opCode == OP_SW) nextState = MEMADR;
            else if (opCode == OP_BEQ)              nextState = BRANCH;
            else if (opCode == OP_J)                nextState = JUMP;
            else if (opCode == OP_JAL)              nextState = JAL;
            else if (opCode == OP_JR)               nextState = JR;
            else if (opCode == OP_ADDI)             nextState = ADDIEX;
            else                                    nextState = EXEC;
         end
         MEMADR: nextState = (opCode == OP_SW) ? MEMWR : MEMRD;
         MEMRD:  if (memReady) nextState = MEMWB; else if (timeout) nextState = ERROR;
         MEMWR:  if (memReady) nextState = FETCH; else if (timeout) nextState = ERROR;
         EXEC:   nextState = ALUWB;
         ADDIEX: nextState = ADDIWB;
         MEMWB, ALUWB, BRANCH, JUMP, JAL, JR, ADDIWB: nextState = FETCH;
         default: nextState = ERROR;
      endcase
   end

   // State, wait counter and registered control word; reset lands directly on FETCH controls.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stateQ  <= FETCH;
         waitCnt <= '0;
         ctrlQ   <= decodeCtrl(FETCH);
      end else begin
         stateQ <= nextState;
         ctrlQ  <= decodeCtrl(nextState);
         if (nextState != stateQ)
            waitCnt <= '0;
         else if (waiting && !memReady && (MEM_TIMEOUT != 0))
            waitCnt <= waitCnt + 1'b1;
      end
   end

   // Instruction fetch completes in the same cycle memory answers.
   assign IRWrite     = (stateQ == FETCH) && memReady;
   assign PCWrite     = ctrlQ.pcWrite | IRWrite;
   assign PCWriteCond = ctrlQ.pcWriteCond;
   assign IorD        = ctrlQ.iorD;
   assign MemRead     = ctrlQ.memRead;
   assign MemWrite    = ctrlQ.memWrite;
   assign MemtoReg    = ctrlQ.memtoReg;
   assign RegWrite    = ctrlQ.regWrite;
   assign RegDst      = ctrlQ.regDst;
   assign ALUSrcA     = ctrlQ.aluSrcA;
   assign ALUSrcB     = ctrlQ.aluSrcB;
   assign ALUOp       = ctrlQ.aluOp;
   assign PCSource    = ctrlQ.pcSource;
   assign RegDstJAL   = ctrlQ.regDstJal;
   assign MemtoRegJAL = ctrlQ.memtoRegJal;
   assign memError    = ctrlQ.memError;
   assign state       = stateQ;

endmodule
